// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers.
// Used by the receive engine and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_DEF        = 7;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // Index of the last data bit for a word length.
  function automatic logic [2:0] last_bit(
    input logic [1:0] wls
  );
    logic [2:0] r;
    r = 3'd7;
    unique case (wls)
      WLS_5: r = 3'd4;
      WLS_6: r = 3'd5;
      WLS_7: r = 3'd6;
      WLS_8: r = 3'd7;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  // Expected parity bit; unused data MSBs must be zero.
  function automatic logic parity_calc(
    input logic [7:0] d,
    input logic       eps,
    input logic       sp
  );
    return sp ? ~eps : ((^d) ^ ~eps);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Push bundle from the receive engine
// into the RX FIFO / LSR logic.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;
  logic       rx_push;

  modport master (
    output rx_data, rx_pe, rx_fe,
    output rx_bi, rx_push
  );

  modport slave (
    input rx_data, rx_pe, rx_fe,
    input rx_bi, rx_push
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous
// input, with a configurable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rst) ff_q <= {2{RST_VAL}};
    else      ff_q <= {ff_q[0], d};
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receive engine:
// deframes 5-8 data bits, parity, stop.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MID        = MID_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  uart_rx_core_if.master rxf,
  output logic       rx_busy
);

  rx_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic       zero_q, zero_d;
  logic       perr_q, perr_d;
  logic [1:0] wls_q, wls_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       sp_q, sp_d;
  logic [7:0] data_q, data_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       bi_q, bi_d;
  logic       push_q, push_d;
  logic       rxs;
  logic       t_mid, t_last;

  // Only the first stop bit is ever checked.
  logic unused_stb;
  assign unused_stb = stb;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  assign t_mid  = baud_pulse &&
                  (cnt_q == 4'(MID));
  assign t_last = baud_pulse &&
                  (cnt_q == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (baud_pulse && !rxs)
          state_d = START;
      START:
        if (t_mid)
          state_d = rxs ? IDLE : DATA;
      DATA:
        if (t_last &&
            idx_q == last_bit(wls_q))
          state_d = pen_q ? PARITY : STOP;
      PARITY:
        if (t_last) state_d = STOP;
      STOP:
        if (t_last)
          state_d = (zero_q && !rxs) ?
                    BRK_WAIT : IDLE;
      BRK_WAIT:
        if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    zero_d = zero_q;
    perr_d = perr_q;
    wls_d  = wls_q;
    pen_d  = pen_q;
    eps_d  = eps_q;
    sp_d   = sp_q;
    data_d = data_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    bi_d   = bi_q;
    push_d = 1'b0;
    unique case (state_q)
      IDLE:
        if (baud_pulse && !rxs) begin
          cnt_d = '0;
          wls_d = wls;
          pen_d = pen;
          eps_d = eps;
          sp_d  = sp;
        end
      START:
        if (t_mid) begin
          // Realign so later samples hit cnt==15.
          cnt_d  = '0;
          idx_d  = '0;
          sh_d   = '0;
          zero_d = 1'b1;
          perr_d = 1'b0;
        end else if (baud_pulse) begin
          cnt_d = cnt_q + 4'd1;
        end
      DATA: begin
        if (baud_pulse) cnt_d = cnt_q + 4'd1;
        if (t_last) begin
          sh_d[idx_q] = rxs;
          zero_d      = zero_q & ~rxs;
          idx_d       = idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (baud_pulse) cnt_d = cnt_q + 4'd1;
        if (t_last) begin
          perr_d = rxs ^ parity_calc(
                     sh_q, eps_q, sp_q);
          zero_d = zero_q & ~rxs;
        end
      end
      STOP: begin
        if (baud_pulse) cnt_d = cnt_q + 4'd1;
        if (t_last) begin
          data_d = sh_q;
          pe_d   = perr_q;
          fe_d   = ~rxs;
          bi_d   = zero_q & ~rxs;
          push_d = 1'b1;
        end
      end
      BRK_WAIT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      zero_q <= 1'b0;
      perr_q <= 1'b0;
      wls_q  <= WLS_8;
      pen_q  <= 1'b0;
      eps_q  <= 1'b0;
      sp_q   <= 1'b0;
      data_q <= '0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      bi_q   <= 1'b0;
      push_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      zero_q <= zero_d;
      perr_q <= perr_d;
      wls_q  <= wls_d;
      pen_q  <= pen_d;
      eps_q  <= eps_d;
      sp_q   <= sp_d;
      data_q <= data_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
      bi_q   <= bi_d;
      push_q <= push_d;
    end
  end

  assign rxf.rx_data = data_q;
  assign rxf.rx_pe   = pe_q;
  assign rxf.rx_fe   = fe_q;
  assign rxf.rx_bi   = bi_q;
  assign rxf.rx_push = push_q;
  assign rx_busy     = (state_q != IDLE);

endmodule
